aq_hpcp_cnt_bank: RTL and testbench
===================================

// Module: aq_hpcp_cnt_bank
// PURPOSE
//  Parametrised bank of CNT_NUM hardware performance counters for the HPCP unit.
//  - Each channel has a programmable event selector, an inhibit bit and a CSR-writable counter.
//  - Each channel has a sticky overflow flag; an optional maskable overflow interrupt is provided.
//  - Sits between the core event sources and the CP0 HPCP CSR read/write path.
// PARAMETERS
//  CNT_NUM    4   number of counter channels
//  CNT_WIDTH  64  counter width in bits (16..64)
//  EVT_NUM    16  number of event pulse inputs; event code 0 = "no event"
//  EVT_SEL_W  5   event-select width; must satisfy 2**EVT_SEL_W > EVT_NUM
// PORTS
//  forever_cpuclk in  1                   free-running core clock
//  cpurst         in  1                   asynchronous reset, active-high
//  hpcp_cnt_en    in  1                   global count enable
//  hpcp_evt       in  EVT_NUM             event pulses; bit k = event code k+1
//  cnt_inhibit    in  CNT_NUM             per-channel count inhibit
//  cfg_wen        in  CNT_NUM             write the event selector of channel i
//  cfg_wdata      in  EVT_SEL_W           event-select write data
//  cnt_wen        in  CNT_NUM             write the counter of channel i
//  hpcp_wdata     in  CNT_WIDTH           counter write data
//  of_clr         in  CNT_NUM             clear the sticky overflow flag of channel i
//  of_ie          in  CNT_NUM             overflow interrupt enable (ignored without macro)
//  cnt_value      out CNT_NUM*CNT_WIDTH   counter values; channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//  cnt_evt_sel    out CNT_NUM*EVT_SEL_W   current event selectors
//  cnt_of         out CNT_NUM             sticky overflow flags
//  hpcp_of_irq    out 1                   level overflow interrupt
// BEHAVIOUR
//  Reset: all counters, selectors, event pipe regs and cnt_of go to 0; hpcp_of_irq=0.
//  Pipeline: hpcp_evt and hpcp_cnt_en are registered once (evt_ff, en_ff).
//    inc_i = en_ff & ~cnt_inhibit[i] & (sel_i!=0) & (sel_i<=EVT_NUM) & evt_ff[sel_i-1].
//    Event-to-count latency is 2 cycles: a pulse at edge N is visible in cnt_value after edge N+1.
//  Counter update, in priority order per channel:
//    1. cnt_wen[i]: load hpcp_wdata[CNT_WIDTH-1:0]; any inc in the same cycle is dropped.
//    2. inc_i: counter <= counter+1, computed as a CNT_WIDTH+1 adder; carry-out = overflow.
//    3. otherwise hold.
//  Wrap-around: all-ones + inc -> 0 and set cnt_of[i] (sticky).
//  cnt_of[i] holds until of_clr[i]. Same-cycle overflow and of_clr: set wins (no event lost).
//  cfg_wen[i]: takes effect the next cycle. An event already in evt_ff is matched against the
//    old selector this cycle and the new one thereafter.
//  Selector values > EVT_NUM are stored as written but never count.
//  Multiple cfg_wen/cnt_wen bits may be set together; all selected channels take the same data.
//  Reset asserted mid-operation clears everything immediately; pending events are lost.
//  Clock gating: one gated_clk_cell per channel, local_en = inc_i|cnt_wen[i]|cfg_wen[i]|of_clr[i]|ovf_i.
//    The event pipe regs stay on forever_cpuclk.
// CONFIGURATION
//  AQ_HPCP_OF_IRQ_EN defined:
//    hpcp_of_irq registered = |(cnt_of & of_ie); asserts 1 cycle after the flag sets.
//    Deasserts 1 cycle after of_clr or after of_ie drops.
//  Undefined: hpcp_of_irq tied 0, of_ie unused, no irq flop. cnt_of behaviour is unchanged.
// STRUCTURE
//  aq_hpcp_pkg:
//    - constants: AQ_HPCP_EVT_NONE=0, default widths
//    - typedef of the per-channel config struct {sel, inhibit}
//  Sub-module aq_hpcp_cnt_chan: one channel, generated CNT_NUM times. Contains the gated clock,
//    selector reg, counter, CNT_WIDTH+1 adder and overflow flag.
//  Top level holds the event pipe regs, the irq reduction and port flattening.
// TESTING
//  1. Reset: pulse cpurst mid-count -> all cnt_value=0, cnt_of=0, hpcp_of_irq=0 same cycle.
//  2. Event select: sel0=3, en=1, pulse hpcp_evt[2] for 5 cycles -> ch0 reads 5 two cycles
//     after the last pulse; ch1 (sel=0) stays 0.
//  3. Overflow: CNT_WIDTH=16, write ch2=16'hFFFE, sel matches a constant event ->
//     FFFF, then 0000 with cnt_of[2]=1. With the macro and of_ie[2]=1, irq=1 the next cycle.
//     of_clr[2] -> flag and irq drop.
//  4. Write vs inc: cnt_wen[0] with hpcp_wdata=100 while inc active -> reads 100 (not 101),
//     then 101 next cycle.
//  5. Inhibit/global: cnt_inhibit[1]=1 or hpcp_cnt_en=0 (registered) -> ch1 holds value.
//     Release -> resumes counting after 1 cycle.
//  6. Overflow/clear collision: of_clr[3] on the wrap cycle -> cnt_of[3] stays 1.
//     Selector 31 (>EVT_NUM) -> never counts.

Source files
------------

// File: rtl/aq_hpcp_cnt_bank_pkg.sv
// Shared constants and types for the HPCP counter bank.
//   AQ_HPCP_EVT_NONE : selector code meaning "no event"; a channel with
//                      this code never counts.
//   *_DEF            : default parameter values used by the bank and its channels.
//   aq_hpcp_cfg_t    : per-channel configuration {sel, inhibit} at default widths.
package aq_hpcp_cnt_bank_pkg;

    localparam int AQ_HPCP_EVT_NONE      = 0;
    localparam int AQ_HPCP_CNT_NUM_DEF   = 4;
    localparam int AQ_HPCP_CNT_WIDTH_DEF = 64;
    localparam int AQ_HPCP_EVT_NUM_DEF   = 16;
    localparam int AQ_HPCP_EVT_SEL_W_DEF = 5;

    typedef struct packed {
        logic [AQ_HPCP_EVT_SEL_W_DEF-1:0] sel;
        logic                             inhibit;
    } aq_hpcp_cfg_t;

endpackage

// File: rtl/aq_hpcp_cnt_bank_if.sv
// Bundle of the counter-bank control/status signals between the event and
// CSR side (master) and the counter bank (slave).
//   master : drives enable, events, inhibit, writes and overflow clear/enable;
//            receives counter values, selectors, overflow flags and the irq.
//   slave  : the counter bank.
interface aq_hpcp_cnt_bank_if #(
    parameter int CNT_NUM   = 4,
    parameter int CNT_WIDTH = 64,
    parameter int EVT_NUM   = 16,
    parameter int EVT_SEL_W = 5
);
    logic                           hpcp_cnt_en;
    logic [EVT_NUM-1:0]             hpcp_evt;
    logic [CNT_NUM-1:0]             cnt_inhibit;
    logic [CNT_NUM-1:0]             cfg_wen;
    logic [EVT_SEL_W-1:0]           cfg_wdata;
    logic [CNT_NUM-1:0]             cnt_wen;
    logic [CNT_WIDTH-1:0]           hpcp_wdata;
    logic [CNT_NUM-1:0]             of_clr;
    logic [CNT_NUM-1:0]             of_ie;
    logic [CNT_NUM*CNT_WIDTH-1:0]   cnt_value;
    logic [CNT_NUM*EVT_SEL_W-1:0]   cnt_evt_sel;
    logic [CNT_NUM-1:0]             cnt_of;
    logic                           hpcp_of_irq;

    modport master (
        output hpcp_cnt_en, hpcp_evt, cnt_inhibit, cfg_wen, cfg_wdata,
               cnt_wen, hpcp_wdata, of_clr, of_ie,
        input  cnt_value, cnt_evt_sel, cnt_of, hpcp_of_irq
    );

    modport slave (
        input  hpcp_cnt_en, hpcp_evt, cnt_inhibit, cfg_wen, cfg_wdata,
               cnt_wen, hpcp_wdata, of_clr, of_ie,
        output cnt_value, cnt_evt_sel, cnt_of, hpcp_of_irq
    );
endinterface

// File: rtl/aq_hpcp_cnt_bank_chan.sv
// One performance-counter channel: event selector, counter with a
// CNT_WIDTH+1 incrementer (carry-out = overflow) and sticky overflow flag.
// Ports:
//   clk, rst   : channel clock, asynchronous active-high reset
//   evt, en    : registered event vector / global enable from the bank
//   inhibit    : channel count inhibit
//   cfg_wen/cfg_wdata : selector write
//   cnt_wen/wdata     : counter load (wins over an increment)
//   of_clr     : clear overflow flag (a same-cycle overflow wins)
//   cnt, sel, of : counter value, selector, sticky overflow flag
// All state updates are qualified by local_en, the channel's clock-gate
// enable (inc | cnt_wen | cfg_wen | of_clr | ovf).
module aq_hpcp_cnt_bank_chan
    import aq_hpcp_cnt_bank_pkg::*;
#(
    parameter int CNT_WIDTH = AQ_HPCP_CNT_WIDTH_DEF,
    parameter int EVT_NUM   = AQ_HPCP_EVT_NUM_DEF,
    parameter int EVT_SEL_W = AQ_HPCP_EVT_SEL_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EVT_NUM-1:0]   evt,
    input  logic                 en,
    input  logic                 inhibit,
    input  logic                 cfg_wen,
    input  logic [EVT_SEL_W-1:0] cfg_wdata,
    input  logic                 cnt_wen,
    input  logic [CNT_WIDTH-1:0] wdata,
    input  logic                 of_clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [EVT_SEL_W-1:0] sel,
    output logic                 of
);

    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [EVT_SEL_W-1:0] sel_reg;
    logic                 of_reg;
    logic                 hit;
    logic                 inc;
    logic                 ovf;
    logic                 local_en;
    logic [CNT_WIDTH:0]   sum;

    // Only codes 1..EVT_NUM can match, so selectors above EVT_NUM are
    // stored but never count and no out-of-range index is formed.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < EVT_NUM; k++) begin
            if (sel_reg == EVT_SEL_W'(k + 1)) begin
                hit = evt[k];
            end
        end
    end

    assign inc      = en & ~inhibit & (sel_reg != EVT_SEL_W'(AQ_HPCP_EVT_NONE)) & hit;
    assign sum      = {1'b0, cnt_reg} + {{CNT_WIDTH{1'b0}}, 1'b1};
    // A load discards the increment, so it cannot overflow either.
    assign ovf      = inc & ~cnt_wen & sum[CNT_WIDTH];
    assign local_en = inc | cnt_wen | cfg_wen | of_clr | ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            sel_reg <= '0;
            of_reg  <= 1'b0;
        end else if (local_en) begin
            if (cfg_wen) begin
                sel_reg <= cfg_wdata;
            end
            if (cnt_wen) begin
                cnt_reg <= wdata;
            end else if (inc) begin
                cnt_reg <= sum[CNT_WIDTH-1:0];
            end
            if (ovf) begin
                of_reg <= 1'b1;
            end else if (of_clr) begin
                of_reg <= 1'b0;
            end
        end
    end

    assign cnt = cnt_reg;
    assign sel = sel_reg;
    assign of  = of_reg;

endmodule

// File: rtl/aq_hpcp_cnt_bank.sv
// Bank of CNT_NUM hardware performance counters for the HPCP unit.
// Registers the event pulses and global enable once, then feeds CNT_NUM
// channels (aq_hpcp_cnt_bank_chan) and flattens their outputs.
// Ports:
//   forever_cpuclk : free-running core clock
//   cpurst         : asynchronous active-high reset
//   bus            : aq_hpcp_cnt_bank_if slave (events, CSR writes, status)
// Optional macro AQ_HPCP_OF_IRQ_EN: registered level interrupt
//   hpcp_of_irq = |(cnt_of & of_ie). Without it hpcp_of_irq is tied 0.
module aq_hpcp_cnt_bank
    import aq_hpcp_cnt_bank_pkg::*;
#(
    parameter int CNT_NUM   = AQ_HPCP_CNT_NUM_DEF,
    parameter int CNT_WIDTH = AQ_HPCP_CNT_WIDTH_DEF,
    parameter int EVT_NUM   = AQ_HPCP_EVT_NUM_DEF,
    parameter int EVT_SEL_W = AQ_HPCP_EVT_SEL_W_DEF
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    aq_hpcp_cnt_bank_if.slave   bus
);

    logic [EVT_NUM-1:0] evt_ff_reg;
    logic               en_ff_reg;

    // Event pipe stays on the free-running clock.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            evt_ff_reg <= '0;
            en_ff_reg  <= 1'b0;
        end else begin
            evt_ff_reg <= bus.hpcp_evt;
            en_ff_reg  <= bus.hpcp_cnt_en;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CNT_NUM; gi++) begin : g_chan
            aq_hpcp_cnt_bank_chan #(
                .CNT_WIDTH (CNT_WIDTH),
                .EVT_NUM   (EVT_NUM),
                .EVT_SEL_W (EVT_SEL_W)
            ) u_chan (
                .clk       (forever_cpuclk),
                .rst       (cpurst),
                .evt       (evt_ff_reg),
                .en        (en_ff_reg),
                .inhibit   (bus.cnt_inhibit[gi]),
                .cfg_wen   (bus.cfg_wen[gi]),
                .cfg_wdata (bus.cfg_wdata),
                .cnt_wen   (bus.cnt_wen[gi]),
                .wdata     (bus.hpcp_wdata),
                .of_clr    (bus.of_clr[gi]),
                .cnt       (bus.cnt_value[gi*CNT_WIDTH +: CNT_WIDTH]),
                .sel       (bus.cnt_evt_sel[gi*EVT_SEL_W +: EVT_SEL_W]),
                .of        (bus.cnt_of[gi])
            );
        end
    endgenerate

`ifdef AQ_HPCP_OF_IRQ_EN
    logic irq_reg;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(bus.cnt_of & bus.of_ie);
        end
    end

    assign bus.hpcp_of_irq = irq_reg;
`else
    logic unused_of_ie;

    assign unused_of_ie    = |bus.of_ie;
    assign bus.hpcp_of_irq = 1'b0;
`endif

endmodule

// File: tb/tb_aq_hpcp_cnt_bank.sv
// Directed bench for aq_hpcp_cnt_bank with CNT_WIDTH=16.
module tb_aq_hpcp_cnt_bank;

    localparam int CNT_NUM   = 4;
    localparam int CNT_WIDTH = 16;
    localparam int EVT_NUM   = 16;
    localparam int EVT_SEL_W = 5;

`ifdef AQ_HPCP_OF_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    aq_hpcp_cnt_bank_if #(
        .CNT_NUM(CNT_NUM), .CNT_WIDTH(CNT_WIDTH),
        .EVT_NUM(EVT_NUM), .EVT_SEL_W(EVT_SEL_W)
    ) bus ();

    aq_hpcp_cnt_bank #(
        .CNT_NUM(CNT_NUM), .CNT_WIDTH(CNT_WIDTH),
        .EVT_NUM(EVT_NUM), .EVT_SEL_W(EVT_SEL_W)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    function automatic logic [15:0] ch(input int i);
        return bus.cnt_value[i*CNT_WIDTH +: CNT_WIDTH];
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.hpcp_cnt_en = 1'b0;
        bus.hpcp_evt    = '0;
        bus.cnt_inhibit = '0;
        bus.cfg_wen     = '0;
        bus.cfg_wdata   = '0;
        bus.cnt_wen     = '0;
        bus.hpcp_wdata  = '0;
        bus.of_clr      = '0;
        bus.of_ie       = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_cnt", {48'd0, bus.cnt_value[15:0]} | 64'(bus.cnt_value), 64'd0);
        chk("rst_sel", 64'(bus.cnt_evt_sel), 64'd0);
        chk("rst_of",  64'(bus.cnt_of), 64'd0);
        chk("rst_irq", 64'(bus.hpcp_of_irq), 64'd0);

        // Event select: ch0 sel=3, five pulses of event code 3
        bus.cfg_wen = 4'b0001; bus.cfg_wdata = 5'd3; bus.hpcp_cnt_en = 1'b1;
        tick();
        bus.cfg_wen = '0;
        chk("sel0_eq3", 64'(bus.cnt_evt_sel[4:0]), 64'd3);
        bus.hpcp_evt = 16'h0004;
        repeat (5) tick();
        bus.hpcp_evt = '0;
        chk("evt_lat_4", 64'(ch(0)), 64'd4);
        tick();
        chk("evt_cnt_5", 64'(ch(0)), 64'd5);
        tick();
        chk("evt_hold_5", 64'(ch(0)), 64'd5);
        chk("ch1_sel0", 64'(ch(1)), 64'd0);

        // Inhibit / global enable on ch1 (sel=1, constant event)
        bus.cfg_wen = 4'b0010; bus.cfg_wdata = 5'd1;
        tick();
        bus.cfg_wen = '0;
        bus.hpcp_evt = 16'h0001;
        tick();
        tick();
        chk("inh_cnt1", 64'(ch(1)), 64'd1);
        tick();
        bus.cnt_inhibit = 4'b0010;
        tick();
        tick();
        chk("inh_hold2", 64'(ch(1)), 64'd2);
        bus.cnt_inhibit = '0;
        tick();
        chk("inh_rel3", 64'(ch(1)), 64'd3);
        bus.hpcp_cnt_en = 1'b0;
        tick();
        tick();
        chk("en_off4", 64'(ch(1)), 64'd4);
        bus.hpcp_cnt_en = 1'b1;
        tick();
        chk("en_lag4", 64'(ch(1)), 64'd4);
        tick();
        chk("en_on5", 64'(ch(1)), 64'd5);
        bus.hpcp_evt = '0;
        tick();
        tick();
        chk("ch1_end6", 64'(ch(1)), 64'd6);

        // Write beats increment on ch0
        bus.hpcp_evt = 16'h0004;
        tick();
        bus.cnt_wen = 4'b0001; bus.hpcp_wdata = 16'd100;
        tick();
        bus.cnt_wen = '0;
        chk("wr_100", 64'(ch(0)), 64'd100);
        tick();
        chk("wr_inc101", 64'(ch(0)), 64'd101);
        bus.hpcp_evt = '0;
        tick();
        tick();
        chk("wr_hold102", 64'(ch(0)), 64'd102);

        // Overflow on ch2
        bus.cfg_wen = 4'b0100; bus.cfg_wdata = 5'd1;
        bus.cnt_wen = 4'b0100; bus.hpcp_wdata = 16'hFFFE;
        bus.of_ie = 4'b0100; bus.hpcp_evt = 16'h0001;
        tick();
        bus.cfg_wen = '0; bus.cnt_wen = '0;
        chk("ovf_load", 64'(ch(2)), 64'hFFFE);
        tick();
        chk("ovf_ffff", 64'(ch(2)), 64'hFFFF);
        chk("ovf_of0", 64'(bus.cnt_of), 64'd0);
        tick();
        chk("ovf_wrap", 64'(ch(2)), 64'd0);
        chk("ovf_of_set", 64'(bus.cnt_of), 64'b0100);
        chk("ovf_irq_lag", 64'(bus.hpcp_of_irq), 64'd0);
        bus.hpcp_evt = '0;
        tick();
        chk("ovf_after1", 64'(ch(2)), 64'd1);
        chk("ovf_irq", 64'(bus.hpcp_of_irq), 64'(IRQ_ON));
        bus.of_clr = 4'b0100;
        tick();
        bus.of_clr = '0;
        chk("ofclr_flag", 64'(bus.cnt_of), 64'd0);
        chk("ofclr_irq_lag", 64'(bus.hpcp_of_irq), 64'(IRQ_ON));
        tick();
        chk("ofclr_irq", 64'(bus.hpcp_of_irq), 64'd0);

        // Overflow / clear collision on ch3
        bus.cfg_wen = 4'b1000; bus.cfg_wdata = 5'd1;
        bus.cnt_wen = 4'b1000; bus.hpcp_wdata = 16'hFFFF;
        bus.hpcp_evt = 16'h0001;
        tick();
        bus.cfg_wen = '0; bus.cnt_wen = '0;
        bus.of_clr = 4'b1000;
        tick();
        bus.of_clr = '0;
        chk("coll_wrap", 64'(ch(3)), 64'd0);
        chk("coll_of", 64'(bus.cnt_of), 64'b1000);
        chk("coll_irq_masked", 64'(bus.hpcp_of_irq), 64'd0);
        bus.of_ie = 4'b1000;
        tick();
        chk("ie_on_irq", 64'(bus.hpcp_of_irq), 64'(IRQ_ON));
        bus.of_ie = '0;
        tick();
        chk("ie_off_irq", 64'(bus.hpcp_of_irq), 64'd0);

        // Selector above EVT_NUM never counts
        bus.cfg_wen = 4'b0001; bus.cfg_wdata = 5'd31;
        bus.hpcp_evt = 16'hFFFF;
        tick();
        bus.cfg_wen = '0;
        tick();
        tick();
        tick();
        chk("sel31_stored", 64'(bus.cnt_evt_sel[4:0]), 64'd31);
        chk("sel31_nocount", 64'(ch(0)), 64'd102);

        // Reset mid-count clears immediately
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cnt", 64'(bus.cnt_value), 64'd0);
        chk("midrst_of", 64'(bus.cnt_of), 64'd0);
        chk("midrst_irq", 64'(bus.hpcp_of_irq), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
